bit_serializer: RTL

//  Parallel-to-serial front end for the single-bit sequence detectors.

---
 rtl/bit_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the serial sequence detectors.
// Takes WIDTH-bit words on a valid/ready handshake and emits them one bit per
// clock on x_o. A single holding register lets a second word queue up while the
// current frame shifts, so consecutive words stream with no gap.
// Optional feature macro: SER_PARITY_EN appends an even-parity bit to each frame.
module bit_serializer #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic             x_o,
   output logic             bit_valid_o,
   output logic             sof_o,
   output logic             eow_o,
   output logic             busy_o
);

`ifdef SER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CNT_W = $clog2(FRAME + 1);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   state_t             r_state;
   logic [FRAME-1:0]   r_sh;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_hold;
   logic               r_hold_full;

   state_t             w_state_next;
   logic [FRAME-1:0]   w_sh_next;
   logic [CNT_W-1:0]   w_cnt_next;
   logic [WIDTH-1:0]   w_hold_next;
   logic               w_hold_full_next;
   logic               w_hs;
   logic               w_last;
   logic               w_bit;

   // Build the shifter image of a word: the parity bit sits where it will be
   // shifted out last, so the shifter alone decides the emitted order.
   function automatic logic [FRAME-1:0] f_frame(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
      if (MSB_FIRST != 0) return {d, ^d};
      else                return {^d, d};
`else
      return d;
`endif
   endfunction

   // Ready depends only on the holding register, never on valid_i.
   assign ready_o = ~r_hold_full;
   assign w_hs    = valid_i & ~r_hold_full;
   assign w_last  = (r_cnt == CNT_W'(FRAME - 1));
   assign w_bit   = (MSB_FIRST != 0) ? r_sh[FRAME-1] : r_sh[0];

   assign bit_valid_o = (r_state == ST_SHIFT);
   assign x_o         = bit_valid_o ? w_bit : IDLE_LEVEL;
   assign sof_o       = bit_valid_o && (r_cnt == '0);
   assign eow_o       = bit_valid_o && w_last;
   assign busy_o      = (r_state == ST_SHIFT) | r_hold_full;

   // State register; reset aborts any frame and discards the held word at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sh        <= '0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_sh        <= w_sh_next;
         r_cnt       <= w_cnt_next;
         r_hold      <= w_hold_next;
         r_hold_full <= w_hold_full_next;
      end
   end

   // Next-state logic: load/shift the frame and manage the holding register.
   always_comb begin
      w_state_next     = r_state;
      w_sh_next        = r_sh;
      w_cnt_next       = r_cnt;
      w_hold_next      = r_hold;
      w_hold_full_next = r_hold_full;
      case (r_state)
         ST_IDLE: begin
            if (r_hold_full) begin
               w_sh_next        = f_frame(r_hold);
               w_hold_full_next = 1'b0;
               w_cnt_next       = '0;
               w_state_next     = ST_SHIFT;
            end else if (w_hs) begin
               w_sh_next    = f_frame(data_i);
               w_cnt_next   = '0;
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A word offered mid-frame is parked in the holding register.
            if (w_hs) begin
               w_hold_next      = data_i;
               w_hold_full_next = 1'b1;
            end
            if (w_last) begin
               if (r_hold_full) begin
                  // Reload the parked word with no idle cycle between frames.
                  w_sh_next        = f_frame(r_hold);
                  w_hold_full_next = 1'b0;
                  w_cnt_next       = '0;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
               if (MSB_FIRST != 0) w_sh_next = {r_sh[FRAME-2:0], 1'b0};
               else                w_sh_next = {1'b0, r_sh[FRAME-1:1]};
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule
